// File: rtl/id_ex_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : id_ex_stage_pkg
// Purpose  : Shared widths, ALU opcodes and forward-select encoding for ID/EX.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package id_ex_stage_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_unit.sv
//------------------------------------------------------------------------------
// Module   : fwd_unit
// Purpose  : Bypass select for one EX source operand (MEM stage beats WB stage).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic            exm_reg_wen,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_reg_wen,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  output fwd_sel_e        sel,
  output logic [XLEN-1:0] operand
);

  logic exm_hit;
  logic mwb_hit;

  // x0 is hardwired zero, so a write to it is never a bypass source
  assign exm_hit = exm_reg_wen && (exm_rd != '0) && (exm_rd == rs);
  assign mwb_hit = mwb_reg_wen && (mwb_rd != '0) && (mwb_rd == rs);

  // operand carries the bypassed value; it is only meaningful when sel != FWD_RF
  always_comb begin
    sel     = FWD_RF;
    operand = '0;
    if (exm_hit) begin
      sel     = FWD_EXM;
      operand = exm_result;
    end else if (mwb_hit) begin
      sel     = FWD_MWB;
      operand = mwb_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use stall, flush and forwarding.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alu_sel,
  input  logic            id_asel,
  input  logic            id_bsel,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_wen,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_reg_wen,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic            mwb_reg_wen,
  input  logic [XLEN-1:0] mwb_result,
  input  logic            flush,
  output logic            stall_id,
  output logic            ex_valid,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_wen,
  output logic [RA_W-1:0] ex_rd,
  output logic [3:0]      ex_alu_sel,
  output logic [XLEN-1:0] ex_in1,
  output logic [XLEN-1:0] ex_in2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc
);

  logic            valid_d,     valid_q;
  logic            mem_read_d,  mem_read_q;
  logic            mem_write_d, mem_write_q;
  logic            reg_wen_d,   reg_wen_q;
  logic            asel_d,      asel_q;
  logic            bsel_d,      bsel_q;
  logic [3:0]      alu_sel_d,   alu_sel_q;
  logic [RA_W-1:0] rd_d,        rd_q;
  logic [RA_W-1:0] rs1_d,       rs1_q;
  logic [RA_W-1:0] rs2_d,       rs2_q;
  logic [XLEN-1:0] pc_d,        pc_q;
  logic [XLEN-1:0] imm_d,       imm_q;
  logic [XLEN-1:0] rs1_data_d,  rs1_data_q;
  logic [XLEN-1:0] rs2_data_d,  rs2_data_q;

  logic            load_use;
  logic            capture;
  logic            out_en;
  fwd_sel_e        rs1_sel;
  fwd_sel_e        rs2_sel;
  logic [XLEN-1:0] rs1_bypass;
  logic [XLEN-1:0] rs2_bypass;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign load_use = id_valid && valid_q && mem_read_q && (rd_q != '0) &&
                    ((rd_q == id_rs1) || (rd_q == id_rs2));
  // flush squashes the consumer anyway, so it never needs to hold IF/ID
  assign stall_id = load_use && !flush && !rst;
  assign capture  = id_valid && !flush && !load_use;

  // A bubble zeroes every field so no stale rd/rs can match downstream
  always_comb begin
    valid_d     = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_wen_d   = 1'b0;
    asel_d      = 1'b0;
    bsel_d      = 1'b0;
    alu_sel_d   = ALU_ADD;
    rd_d        = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    pc_d        = '0;
    imm_d       = '0;
    rs1_data_d  = '0;
    rs2_data_d  = '0;
    if (capture) begin
      valid_d     = 1'b1;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
      reg_wen_d   = id_reg_wen;
      asel_d      = id_asel;
      bsel_d      = id_bsel;
      alu_sel_d   = id_alu_sel;
      rd_d        = id_rd;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      pc_d        = id_pc;
      imm_d       = id_imm;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_wen_q   <= 1'b0;
      asel_q      <= 1'b0;
      bsel_q      <= 1'b0;
      alu_sel_q   <= ALU_ADD;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_wen_q   <= reg_wen_d;
      asel_q      <= asel_d;
      bsel_q      <= bsel_d;
      alu_sel_q   <= alu_sel_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
    end
  end

  fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs          (rs1_q),
    .exm_reg_wen (exm_reg_wen),
    .exm_rd      (exm_rd),
    .exm_result  (exm_result),
    .mwb_reg_wen (mwb_reg_wen),
    .mwb_rd      (mwb_rd),
    .mwb_result  (mwb_result),
    .sel         (rs1_sel),
    .operand     (rs1_bypass)
  );

  fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs          (rs2_q),
    .exm_reg_wen (exm_reg_wen),
    .exm_rd      (exm_rd),
    .exm_result  (exm_result),
    .mwb_reg_wen (mwb_reg_wen),
    .mwb_rd      (mwb_rd),
    .mwb_result  (mwb_result),
    .sel         (rs2_sel),
    .operand     (rs2_bypass)
  );

  assign rs1_fwd = (rs1_sel == FWD_RF) ? rs1_data_q : rs1_bypass;
  assign rs2_fwd = (rs2_sel == FWD_RF) ? rs2_data_q : rs2_bypass;

  // Outputs read as a clean bubble while reset is held, before the edge clears state
  assign out_en        = valid_q && !rst;
  assign ex_valid      = out_en;
  assign ex_mem_read   = out_en && mem_read_q;
  assign ex_mem_write  = out_en && mem_write_q;
  assign ex_reg_wen    = out_en && reg_wen_q;
  assign ex_rd         = out_en ? rd_q      : '0;
  assign ex_alu_sel    = out_en ? alu_sel_q : ALU_ADD;
  assign ex_pc         = out_en ? pc_q      : '0;
  assign ex_in1        = out_en ? (asel_q ? pc_q  : rs1_fwd) : '0;
  assign ex_in2        = out_en ? (bsel_q ? imm_q : rs2_fwd) : '0;
  assign ex_store_data = out_en ? rs2_fwd : '0;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_id_ex_stage
// Purpose  : Directed self-checking bench for id_ex_stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_sel;
  logic        id_asel, id_bsel, id_mem_read, id_mem_write, id_reg_wen;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_reg_wen, mwb_reg_wen;
  logic [31:0] exm_result, mwb_result;
  logic        flush;
  logic        stall_id;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_wen;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_sel;
  logic [31:0] ex_in1, ex_in2, ex_store_data, ex_pc;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_sel(id_alu_sel),
    .id_asel(id_asel), .id_bsel(id_bsel), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_wen(id_reg_wen),
    .exm_rd(exm_rd), .exm_reg_wen(exm_reg_wen), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_reg_wen(mwb_reg_wen), .mwb_result(mwb_result),
    .flush(flush), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_wen(ex_reg_wen), .ex_rd(ex_rd), .ex_alu_sel(ex_alu_sel),
    .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_store_data(ex_store_data), .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] r1d, input logic [31:0] r2d,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [3:0] alu, input logic asel, input logic bsel,
                        input logic mr, input logic mw, input logic wen);
    id_valid = v; id_pc = pc; id_imm = imm; id_rs1_data = r1d; id_rs2_data = r2d;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_sel = alu;
    id_asel = asel; id_bsel = bsel; id_mem_read = mr; id_mem_write = mw; id_reg_wen = wen;
  endtask

  task automatic set_fwd(input logic [4:0] erd, input logic ewen, input logic [31:0] eres,
                         input logic [4:0] mrd, input logic mwen, input logic [31:0] mres);
    exm_rd = erd; exm_reg_wen = ewen; exm_result = eres;
    mwb_rd = mrd; mwb_reg_wen = mwen; mwb_result = mres;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h40, 32'h8, 32'h11, 32'h22, 1, 2, 3, 4'h0, 0, 0, 1, 0, 1);

    // Reset held across two edges
    tick;
    tick;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_id}, 32'd0);
    chk("rst_in1", ex_in1, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_rd", {27'd0, ex_rd}, 32'd0);

    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    tick;
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("post_rst_in2", ex_in2, 32'd0);

    // add x3,x1,x2 with no bypass
    set_id(1, 32'h100, 32'h0, 32'd5, 32'd7, 1, 2, 3, 4'h0, 0, 0, 0, 0, 1);
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_in1", ex_in1, 32'd5);
    chk("add_in2", ex_in2, 32'd7);
    chk("add_rd", {27'd0, ex_rd}, 32'd3);
    chk("add_pc", ex_pc, 32'h100);
    chk("add_sd", ex_store_data, 32'd7);
    chk("add_wen", {31'd0, ex_reg_wen}, 32'd1);

    // Bypass priority on the add held in EX
    set_fwd(1, 1, 32'h10, 1, 1, 32'h20);
    #1;
    chk("fwd_exm_prio", ex_in1, 32'h10);
    set_fwd(1, 0, 32'h10, 1, 1, 32'h20);
    #1;
    chk("fwd_mwb_only", ex_in1, 32'h20);
    set_fwd(1, 1, 32'h10, 2, 1, 32'h20);
    #1;
    chk("fwd_both_in1", ex_in1, 32'h10);
    chk("fwd_both_in2", ex_in2, 32'h20);
    chk("fwd_both_sd", ex_store_data, 32'h20);

    // x0 never forwarded; immediate on in2; store data still rs2
    set_fwd(0, 1, 32'hFFFF, 0, 0, 0);
    set_id(1, 32'h104, 32'h44, 32'd0, 32'd9, 0, 0, 4, 4'h0, 0, 1, 0, 1, 0);
    tick;
    chk("x0_in1", ex_in1, 32'd0);
    chk("x0_in2_imm", ex_in2, 32'h44);
    chk("x0_sd", ex_store_data, 32'd9);
    chk("x0_memw", {31'd0, ex_mem_write}, 32'd1);

    // PC on in1, LUI opcode passes through
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h200, 32'h0, 32'h33, 32'h77, 1, 7, 8, 4'hA, 1, 0, 0, 0, 1);
    tick;
    chk("asel_in1", ex_in1, 32'h200);
    chk("asel_in2", ex_in2, 32'h77);
    chk("asel_alu", {28'd0, ex_alu_sel}, 32'hA);

    // Load-use: lw x5 then add x6,x5,x0
    set_id(1, 32'h300, 32'h4, 32'h1000, 32'h0, 2, 0, 5, 4'h0, 0, 1, 1, 0, 1);
    tick;
    chk("lw_mr", {31'd0, ex_mem_read}, 32'd1);
    chk("lw_in1", ex_in1, 32'h1000);
    chk("lw_in2", ex_in2, 32'h4);
    set_id(1, 32'h304, 32'h0, 32'h55, 32'h0, 5, 0, 6, 4'h0, 0, 0, 0, 0, 1);
    #1;
    chk("lu_stall", {31'd0, stall_id}, 32'd1);
    tick;
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_mr", {31'd0, ex_mem_read}, 32'd0);
    chk("lu_bub_wen", {31'd0, ex_reg_wen}, 32'd0);
    chk("lu_bub_in1", ex_in1, 32'd0);
    chk("lu_stall_drop", {31'd0, stall_id}, 32'd0);
    tick;
    set_fwd(0, 0, 0, 5, 1, 32'hAB);
    #1;
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_in1", ex_in1, 32'hAB);
    chk("lu_add_rd", {27'd0, ex_rd}, 32'd6);
    chk("lu_add_pc", ex_pc, 32'h304);

    // Stall condition together with flush
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h400, 32'h0, 32'h20, 32'h0, 0, 0, 7, 4'h0, 0, 1, 1, 0, 1);
    tick;
    set_id(1, 32'h404, 32'h0, 32'd1, 32'd1, 7, 7, 8, 4'h0, 0, 0, 0, 0, 1);
    flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, stall_id}, 32'd0);
    tick;
    flush = 1'b0;
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_wen", {31'd0, ex_reg_wen}, 32'd0);
    tick;
    chk("after_fl_valid", {31'd0, ex_valid}, 32'd1);
    chk("after_fl_rd", {27'd0, ex_rd}, 32'd8);

    // id_valid=0 loads a bubble
    set_id(0, 32'h500, 32'h1, 32'h2, 32'h3, 1, 2, 9, 4'h3, 0, 0, 0, 0, 1);
    tick;
    chk("inv_valid", {31'd0, ex_valid}, 32'd0);
    chk("inv_in1", ex_in1, 32'd0);

    // Reset while a load-use stall is pending (rs2 match)
    set_id(1, 32'h600, 32'h0, 32'h10, 32'h0, 1, 0, 5, 4'h0, 0, 0, 1, 0, 1);
    tick;
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    set_id(1, 32'h604, 32'h0, 32'h0, 32'h0, 1, 5, 9, 4'h0, 0, 0, 0, 0, 1);
    #1;
    chk("rs2_stall", {31'd0, stall_id}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_stall_gated", {31'd0, stall_id}, 32'd0);
    chk("rst_during_valid", {31'd0, ex_valid}, 32'd0);
    tick;
    chk("rst_edge_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_edge_mr", {31'd0, ex_mem_read}, 32'd0);
    chk("rst_edge_pc", ex_pc, 32'd0);
    chk("rst_edge_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst_edge_stall", {31'd0, stall_id}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall", {31'd0, stall_id}, 32'd0);
    tick;
    chk("post_rst_issue", {31'd0, ex_valid}, 32'd1);
    chk("post_rst_rd", {27'd0, ex_rd}, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  ID holds a real instruction.
REQ-006 id_pc, id_imm, id_rs1_data, id_rs2_data  input  XLEN each  PC, immediate, register-file read data.
REQ-007 id_rs1, id_rs2, id_rd  input  RA_W each  source/destination addresses.
REQ-008 id_alu_sel  input  4  ALU opcode (0000 add ... 1010 pass-in2).
REQ-009 id_asel, id_bsel  input  1 each  asel=1 selects PC for in1; bsel=1 selects immediate for in2.
REQ-010 id_mem_read, id_mem_write, id_reg_wen  input  1 each  load, store, writeback flags.
REQ-011 exm_rd/mwb_rd  input  RA_W; exm_reg_wen/mwb_reg_wen  input  1; exm_result/mwb_result  input  XLEN  results of the MEM-stage and WB-stage instructions.
REQ-012 flush  input  1  taken branch/jump; kills ID and EX contents.
REQ-013 stall_id  output  1  hold PC and IF/ID register this cycle.
REQ-014 ex_valid, ex_mem_read, ex_mem_write, ex_reg_wen  output  1 each; ex_rd  output  RA_W; ex_alu_sel  output  4.
REQ-015 ex_in1, ex_in2, ex_store_data, ex_pc  output  XLEN each  ALU operands, forwarded rs2 for stores, EX PC.

Function
REQ-016 Stage register captures all id_* fields on every clock edge unless bubble or flush applies.
REQ-017 Load-use hazard: stall_id=1 combinationally when id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-018 On stall_id=1, next-cycle stage register holds a bubble: ex_valid=0, ex_reg_wen=0, ex_mem_read=0, ex_mem_write=0, ex_alu_sel=0000.
REQ-019 On flush=1, next-cycle stage register holds a bubble; flush overrides stall, and stall_id=0 whenever flush=1.
REQ-020 id_valid=0 loads a bubble.
REQ-021 Forwarding, per source operand, evaluated combinationally in EX from registered rs1/rs2: exm match (exm_reg_wen & exm_rd!=0 & exm_rd==rs) selects exm_result; else mwb match selects mwb_result; else registered register-file data.
REQ-022 exm takes priority over mwb when both match; x0 is never forwarded.
REQ-023 ex_in1 = PC if asel else forwarded rs1; ex_in2 = immediate if bsel else forwarded rs2; ex_store_data = forwarded rs2 always.
REQ-024 Latency: ID fields appear on ex_* one cycle after capture; forwarding adds no cycles; a load-use stall costs exactly one bubble.
REQ-025 Bubble outputs: ex_in1/ex_in2/ex_store_data = 0 when ex_valid=0.

Reset
REQ-026 rst=1 at a clock edge forces stage register to bubble state and all stored data/PC/rd to 0, overriding flush and stall.
REQ-027 During and one cycle after reset: ex_valid=0, stall_id=0, all ex_* outputs 0.
REQ-028 Reset asserted mid-stall discards the stalled instruction state; no hazard persists after deassertion.

Structure
REQ-029 Shared package holds XLEN, RA_W, ALU-opcode constants (ADD=0000 ... LUI=1010) and the forward-select enum {FWD_RF, FWD_EXM, FWD_MWB}.
REQ-030 One sub-module, fwd_unit, computes the forward select and operand value for one source; instantiated twice.

Verification
REQ-031 ID add x3,x1,x2 with rs1_data=5, rs2_data=7, no matches -> next cycle ex_in1=5, ex_in2=7, ex_valid=1, ex_rd=3.
REQ-032 EX holds add with exm_rd=1, exm_result=0x10, mwb_rd=1, mwb_result=0x20 -> ex_in1=0x10 (exm priority).
REQ-033 EX holds lw x5, ID holds add x6,x5,x0 -> stall_id=1 one cycle, then bubble with ex_valid=0, then add issues with in1 forwarded from mwb_result.
REQ-034 stall condition and flush=1 same cycle -> stall_id=0, next cycle ex_valid=0.
REQ-035 exm_rd=0, exm_reg_wen=1, exm_result=0xFFFF, id_rs1=0, rs1_data=0 -> ex_in1=0.
REQ-036 rst=1 while ex_valid=1 -> next edge all ex_* outputs 0, stall_id=0.
